divby255_seq: RTL
=================

# divby255_seq

Sequencer that drives the 16-bit divide-by-255 core from a 32-bit dividend source. It latches a 32-bit dividend on `start` and serialises it onto the core's 16-bit `x` bus with the load strobes `flg1` and `flg2`. It then waits for the core to compute, reads the quotient back half by half with `flg3` and `flg4`, and reassembles a 32-bit quotient. Each result is range-checked against the dividend. Sits directly upstream of the divider core and presents a start/done interface to the rest of the datapath.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each strobe phase is held. Legal range 1..255.
- `WAIT_CYCLES`, default 8: idle cycles between the low-half load and the first read. Legal range 0..255.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a transaction. Sampled only in IDLE.
- `dividend`  in  32: operand, latched on the accepted `start` edge.
- `busy`  out  1: high from the accepted start through DONE inclusive.
- `done`  out  1: one-cycle pulse; `quotient` and `chk_err` are valid in this cycle.
- `quotient`  out  32: reassembled quotient. Holds its value until the next `start`.
- `chk_err`  out  1: quotient failed the range check. Holds until the next `start`.
- `x`  out  16: operand half to the core.
- `flg1`  out  1: core strobe, load dividend[31:16] from `x`.
- `flg2`  out  1: core strobe, load dividend[15:0] from `x`.
- `flg3`  out  1: core strobe, core presents quotient[31:16] on `y`.
- `flg4`  out  1: core strobe, core presents quotient[15:0] on `y`.
- `y`  in  16: quotient half from the core.

## Operation
- States: IDLE → LOAD_HI → LOAD_LO → WAIT → READ_HI → READ_LO → DONE → IDLE.
- All outputs are registered. Strobes and `x` are decoded from the state register, so they are glitch-free.
- At most one of `flg1`..`flg4` is high in any cycle. All four are 0 in IDLE, WAIT and DONE.
- IDLE:
  - `start`=1 latches `dividend` into `d_reg`.
  - Clears `quotient` and `chk_err`.
  - Loads the phase counter with `HOLD_CYCLES-1` and enters LOAD_HI.
- LOAD_HI: `x`=`d_reg[31:16]`, `flg1`=1.
- LOAD_LO: `x`=`d_reg[15:0]`, `flg2`=1.
- WAIT: `x` holds its last value; no strobe. When `WAIT_CYCLES`=0, LOAD_LO goes directly to READ_HI.
- READ_HI: `flg3`=1. On the final cycle of the phase, `y` is captured into `quotient[31:16]`.
- READ_LO: `flg4`=1. On the final cycle of the phase, `y` is captured into `quotient[15:0]`.
- Phase counter:
  - 8-bit down-counter.
  - The phase advances when the counter reads 0 at the clock edge.
  - On every phase advance the counter reloads with the next phase's length minus 1.
- Range check, evaluated in READ_LO from `{quotient[31:16], y}`:
  - p = q*255 = (q<<8) − q, computed at 40 bits.
  - `chk_err` = !(p ≤ d_reg && d_reg − p < 255).
  - Registered on the same edge as the low-half capture.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
- `start` asserted while `busy`=1 is ignored; it is not queued.
- `start` held high across DONE→IDLE: a new transaction is accepted on the first IDLE edge.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `chk_err`=0, `x`=0, `flg1`..`flg4`=0, `quotient`=0, `d_reg`=0, counter=0.
- Reset mid-transaction:
  - Strobes drop and the state returns to IDLE immediately (asynchronous).
  - No partial quotient is retained.
  - The first `start` after `rst` deasserts is accepted normally.
- Phase lengths:
  - LOAD_HI, LOAD_LO, READ_HI and READ_LO each last exactly `HOLD_CYCLES` cycles.
  - WAIT lasts exactly `WAIT_CYCLES` cycles.
  - Phases are back-to-back, with no gap cycles.
- Latency: `start` accepted at edge E0 → LOAD_HI outputs visible after E0 → `done` high in the cycle after edge E0 + 4·HOLD_CYCLES + WAIT_CYCLES.
  - With defaults this is 24 cycles.
  - The full transaction, IDLE to IDLE, is 25 cycles.
- `y` must be stable by the last cycle of each read phase. The core therefore gets `HOLD_CYCLES`−1 cycles to respond to `flg3`/`flg4`.
- `x` changes only on phase-boundary edges.

## Test plan
- Bench uses a behavioural core model (latches on `flg1`/`flg2`; `y` = (d/255) half, 1-cycle delay on `flg3`/`flg4`), defaults.
- `dividend`=25500 → `done` at 24 cycles; `quotient`=0x00000064; `chk_err`=0. `x` reads 0x0000 then 0x639C; strobes one-hot, in order flg1, flg2, flg3, flg4.
- `dividend`=255, 0 and 0xFFFFFFFF → `quotient` = 0x00000001, 0x00000000 and 0x01010101 respectively; `chk_err`=0 for each.
- Core model forced to return 0x0065 for the low half with `dividend`=25500 → `quotient`=0x00000065, `chk_err`=1.
- `start` pulsed at cycle 5 of a transaction → ignored. Single `done`; `busy` stays high throughout; the second dividend is never loaded.
- `rst` asserted during READ_HI → strobes 0 immediately, `quotient`=0, `busy`=0. A subsequent 2550 transaction yields 0x0000000A.
- `HOLD_CYCLES`=1, `WAIT_CYCLES`=0 with `dividend`=2550 → `done` 4 cycles after start, `quotient`=0x0000000A.

Source files
------------

// File: rtl/divby255_seq.sv
// divby255_seq: drives a 16-bit divide-by-255 core from a 32-bit dividend.
// The dividend is loaded into the core in two halves. The sequencer waits
// for the core to compute, then reads the quotient back in two halves.
// It reassembles the 32-bit quotient and range-checks it against the dividend.
module divby255_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int WAIT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        chk_err,
    output logic [15:0] x,
    output logic        flg1,
    output logic        flg2,
    output logic        flg3,
    output logic        flg4,
    input  logic [15:0] y
);

    // Counter reload values: each phase runs for (reload + 1) cycles.
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);
    localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_WAIT    = 3'd3,
        S_READ_HI = 3'd4,
        S_READ_LO = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_adv;
    logic        w_accept;
    logic        w_chk_fail;

    logic [31:0] r_dreg;
    logic [31:0] r_quot;
    logic        r_chk;
    logic [15:0] r_x;
    logic        r_flg1;
    logic        r_flg2;
    logic        r_flg3;
    logic        r_flg4;
    logic        r_busy;
    logic        r_done;

    // A quotient q is correct for d when q*255 <= d and d - q*255 < 255.
    // q*255 is formed as (q << 8) - q at 40 bits so nothing can overflow.
    function automatic logic range_fail(input logic [31:0] q, input logic [31:0] d);
        logic [39:0] p;
        logic [39:0] dd;
        p  = {q, 8'd0} - {8'd0, q};
        dd = {8'd0, d};
        return !((p <= dd) && ((dd - p) < 40'd255));
    endfunction

    assign w_adv      = (r_cnt == 8'd0);
    assign w_accept   = (r_state == S_IDLE) && start;
    // The check uses the high half already captured and the live low half from the core.
    assign w_chk_fail = range_fail({r_quot[31:16], y}, r_dreg);

    // State and phase-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. Each phase ends when the counter reads 0. The counter
    // is then reloaded with the length of the next phase.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_HI;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            S_LOAD_HI: begin
                if (w_adv) begin
                    w_state_nxt = S_LOAD_LO;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_LOAD_LO: begin
                if (w_adv) begin
                    if (NO_WAIT) begin
                        w_state_nxt = S_READ_HI;
                        w_cnt_nxt   = HOLD_LD;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WAIT_LD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_WAIT: begin
                if (w_adv) begin
                    w_state_nxt = S_READ_HI;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_READ_HI: begin
                if (w_adv) begin
                    w_state_nxt = S_READ_LO;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_READ_LO: begin
                if (w_adv) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Operand latch, quotient assembly and range-check flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dreg <= 32'd0;
            r_quot <= 32'd0;
            r_chk  <= 1'b0;
        end else if (w_accept) begin
            r_dreg <= dividend;
            r_quot <= 32'd0;
            r_chk  <= 1'b0;
        end else if (w_adv && (r_state == S_READ_HI)) begin
            r_quot[31:16] <= y;
        end else if (w_adv && (r_state == S_READ_LO)) begin
            r_quot[15:0] <= y;
            r_chk        <= w_chk_fail;
        end
    end

    // Operand bus: changes only when entering a load phase, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= 16'd0;
        end else if (w_accept) begin
            r_x <= dividend[31:16];
        end else if (w_adv && (r_state == S_LOAD_HI)) begin
            r_x <= r_dreg[15:0];
        end
    end

    // Strobes and status are registered from the next state so they are
    // glitch-free. They line up exactly with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flg1 <= 1'b0;
            r_flg2 <= 1'b0;
            r_flg3 <= 1'b0;
            r_flg4 <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_flg1 <= (w_state_nxt == S_LOAD_HI);
            r_flg2 <= (w_state_nxt == S_LOAD_LO);
            r_flg3 <= (w_state_nxt == S_READ_HI);
            r_flg4 <= (w_state_nxt == S_READ_LO);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quot;
    assign chk_err  = r_chk;
    assign x        = r_x;
    assign flg1     = r_flg1;
    assign flg2     = r_flg2;
    assign flg3     = r_flg3;
    assign flg4     = r_flg4;

endmodule
